// File: rtl/sram_seq_pkg.sv
// Shared SRAM sequencer/arbiter definitions: bus widths, default scratch address, write request record.
package sram_seq_pkg;

  localparam int ADDR_W = 18;
  localparam int DATA_W = 16;

  localparam logic [ADDR_W-1:0] IDLE_ADDR_DFLT = 18'h3FFFF;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wreq_t;

endpackage

// File: rtl/sram_seq_wfifo.sv
// Write request FIFO: zero-latency head, refuses push when full and pop when empty.
// Exposes every entry's address and live flag so the owner can compare against pending writes.
module sram_seq_wfifo
  import sram_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_push,
  input  logic [ADDR_W-1:0]       i_addr,
  input  logic [DATA_W-1:0]       i_data,
  input  logic                    i_pop,
  output logic [ADDR_W-1:0]       o_addr,
  output logic [DATA_W-1:0]       o_data,
  output logic                    o_full,
  output logic                    o_empty,
  output logic [$clog2(DEPTH):0]  o_count,
  output logic [DEPTH*ADDR_W-1:0] o_ent_addr,
  output logic [DEPTH-1:0]        o_ent_vld
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wreq_t          r_mem [DEPTH];
  logic [PW-1:0]  r_wptr;
  logic [PW-1:0]  r_rptr;
  logic [CW-1:0]  r_count;
  logic           w_push;
  logic           w_pop;
  logic [PW-1:0]  w_off;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_addr  = r_mem[r_rptr].addr;
  assign o_data  = r_mem[r_rptr].data;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= '{addr: i_addr, data: i_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // An entry is live when its distance from the read pointer is below the count.
  always_comb begin
    o_ent_vld = '0;
    w_off     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_off        = PW'(i) - r_rptr;
      o_ent_vld[i] = ({1'b0, w_off} < r_count);
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    assign o_ent_addr[g*ADDR_W +: ADDR_W] = r_mem[g].addr;
  end

endmodule

// File: rtl/sram_req_sequencer.sv
// Drives the two-phase SRAM arbiter: one write issue and one read accept per 2 cycles, reads return READ_LAT edges later, no response backpressure.
// Writes backpressure via wr_ready (FIFO full); define SRAM_SEQ_RAW_STALL_EN to stall reads that hit a queued write.
module sram_req_sequencer
  import sram_seq_pkg::*;
#(
  parameter int                WFIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] IDLE_ADDR   = IDLE_ADDR_DFLT,
  parameter int                READ_LAT    = 3
) (
  input  logic              CLOCK_50,
  input  logic              RESET_N,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_resp_valid,
  output logic [DATA_W-1:0] rd_resp_data,
  output logic [ADDR_W-1:0] w_addr,
  output logic [DATA_W-1:0] w_data,
  output logic [ADDR_W-1:0] r_addr,
  input  logic [DATA_W-1:0] r_data
);

  localparam int CW = $clog2(WFIFO_DEPTH) + 1;

  logic                        r_slot;
  logic [ADDR_W-1:0]           r_w_addr;
  logic [DATA_W-1:0]           r_w_data;
  logic [ADDR_W-1:0]           r_r_addr;
  logic [READ_LAT-1:0]         r_rd_pipe;
  logic                        r_resp_vld;
  logic [DATA_W-1:0]           r_resp_data;

  logic                        w_push;
  logic                        w_pop;
  logic                        w_full;
  logic                        w_empty;
  logic                        w_rd_acc;
  logic                        w_raw_hit;
  logic [ADDR_W-1:0]           w_head_addr;
  logic [DATA_W-1:0]           w_head_data;
  logic [CW-1:0]               w_count;
  logic [WFIFO_DEPTH*ADDR_W-1:0] w_ent_addr;
  logic [WFIFO_DEPTH-1:0]      w_ent_vld;
  logic                        w_unused;

  assign wr_ready      = !w_full;
  assign w_push        = wr_valid && wr_ready;
  assign w_pop         = !r_slot && !w_empty;
  assign rd_ready      = r_slot && !w_raw_hit;
  assign w_rd_acc      = rd_valid && rd_ready;
  assign w_addr        = r_w_addr;
  assign w_data        = r_w_data;
  assign r_addr        = r_r_addr;
  assign rd_resp_valid = r_resp_vld;
  assign rd_resp_data  = r_resp_data;

  sram_seq_wfifo #(
    .DEPTH (WFIFO_DEPTH)
  ) u_wfifo (
    .clk        (CLOCK_50),
    .rst_n      (RESET_N),
    .i_push     (w_push),
    .i_addr     (wr_addr),
    .i_data     (wr_data),
    .i_pop      (w_pop),
    .o_addr     (w_head_addr),
    .o_data     (w_head_data),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_count    (w_count),
    .o_ent_addr (w_ent_addr),
    .o_ent_vld  (w_ent_vld)
  );

`ifdef SRAM_SEQ_RAW_STALL_EN
  always_comb begin
    w_raw_hit = 1'b0;
    for (int i = 0; i < WFIFO_DEPTH; i++) begin
      if (w_ent_vld[i] && (w_ent_addr[i*ADDR_W +: ADDR_W] == rd_addr)) begin
        w_raw_hit = 1'b1;
      end
    end
  end
  assign w_unused = ^w_count;
`else
  assign w_raw_hit = 1'b0;
  assign w_unused  = ^{w_count, w_ent_addr, w_ent_vld};
`endif

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_slot   <= 1'b0;
      r_w_addr <= IDLE_ADDR;
      r_w_data <= '0;
      r_r_addr <= '0;
    end else begin
      r_slot <= ~r_slot;
      // The arbiter writes every write slot, so an empty FIFO parks the write on the scratch address.
      if (!r_slot) begin
        if (!w_empty) begin
          r_w_addr <= w_head_addr;
          r_w_data <= w_head_data;
        end else begin
          r_w_addr <= IDLE_ADDR;
          r_w_data <= '0;
        end
      end
      if (w_rd_acc) r_r_addr <= rd_addr;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_rd_pipe   <= '0;
      r_resp_vld  <= 1'b0;
      r_resp_data <= '0;
    end else begin
      r_rd_pipe  <= {r_rd_pipe[READ_LAT-2:0], w_rd_acc};
      r_resp_vld <= r_rd_pipe[READ_LAT-1];
      if (r_rd_pipe[READ_LAT-1]) r_resp_data <= r_data;
    end
  end

  always @(posedge CLOCK_50) begin
    if (RESET_N) begin
      assert (READ_LAT == 3);
      assert ($countones(r_rd_pipe) <= 2);
    end
  end

endmodule

// File: tb/tb_sram_req_sequencer.sv
// Directed bench for sram_req_sequencer with a two-phase arbiter + SRAM model behind it.
module tb_sram_req_sequencer;
  import sram_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_valid, wr_ready, rd_valid, rd_ready, rd_resp_valid;
  logic [17:0] wr_addr, rd_addr, w_addr, r_addr;
  logic [15:0] wr_data, rd_resp_data, w_data, r_data;

  always #5 clk = ~clk;

  sram_req_sequencer #(
    .WFIFO_DEPTH (4),
    .IDLE_ADDR   (18'h3FFFF),
    .READ_LAT    (3)
  ) dut (
    .CLOCK_50      (clk),
    .RESET_N       (rst_n),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .rd_valid      (rd_valid),
    .rd_ready      (rd_ready),
    .rd_addr       (rd_addr),
    .rd_resp_valid (rd_resp_valid),
    .rd_resp_data  (rd_resp_data),
    .w_addr        (w_addr),
    .w_data        (w_data),
    .r_addr        (r_addr),
    .r_data        (r_data)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Arbiter + SRAM: samples r_addr after slot 0, reads and writes after slot 1.
  logic        m_slot;
  logic [17:0] m_raddr;
  logic [15:0] mem [0:255];
  int          m_cnt;
  int          m_wr_cnt = 0;
  int          resp_cnt = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_slot  <= 1'b0;
      m_raddr <= '0;
      r_data  <= '0;
      m_cnt   <= 0;
      for (int i = 0; i < 256; i++) mem[i] <= 16'h0;
    end else begin
      m_slot <= ~m_slot;
      m_cnt  <= m_cnt + ((wr_valid && m_cnt < 4) ? 1 : 0) - ((!m_slot && m_cnt != 0) ? 1 : 0);
      if (!m_slot) begin
        m_raddr <= r_addr;
      end else begin
        r_data             <= mem[m_raddr[7:0]];
        mem[w_addr[7:0]]   <= w_data;
        if (w_addr != 18'h3FFFF) m_wr_cnt <= m_wr_cnt + 1;
      end
    end
  end

  always @(negedge clk) if (rd_resp_valid) resp_cnt++;

  task automatic push(input logic [17:0] a, input logic [15:0] d, input string tag);
    int n;
    n = 0;
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    while (!wr_ready && n < 20) begin @(negedge clk); n++; end
    check({tag, "_wr_accept"}, 32'(n < 20), 1);
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic do_read(input logic [17:0] a, input logic [15:0] exp, input string tag, output int waited);
    int n;
    n = 0;
    rd_valid = 1'b1; rd_addr = a;
    while (!rd_ready && n < 20) begin @(negedge clk); n++; end
    waited = n;
    check({tag, "_rd_accept"}, 32'(n < 20), 1);
    @(negedge clk);
    rd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check({tag, "_vld_e2"}, rd_resp_valid, 0);
    @(negedge clk);
    check({tag, "_vld_e3"}, rd_resp_valid, 1);
    check({tag, "_data"}, rd_resp_data, exp);
    @(negedge clk);
    check({tag, "_vld_e4"}, rd_resp_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int          waited, base, base_wr, n;
    logic        seen_full, saw_write;
    logic [15:0] exp_raw;

    rst_n = 1'b0; wr_valid = 1'b0; rd_valid = 1'b0;
    wr_addr = '0; wr_data = '0; rd_addr = '0;
    repeat (3) @(negedge clk);
    check("rst_w_addr", w_addr, 18'h3FFFF);
    check("rst_w_data", w_data, 0);
    check("rst_r_addr", r_addr, 0);
    check("rst_wr_ready", wr_ready, 1);
    check("rst_rd_ready", rd_ready, 0);
    check("rst_resp_vld", rd_resp_valid, 0);
    check("rst_resp_data", rd_resp_data, 0);

    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("idle_w_addr", w_addr, 18'h3FFFF);
    check("idle_w_data", w_data, 0);
    check("idle_wr_ready", wr_ready, 1);
    check("idle_no_resp", resp_cnt, 0);

    push(18'h00010, 16'hBEEF, "t2_p0");
    push(18'h00011, 16'hCAFE, "t2_p1");
    repeat (8) @(negedge clk);
    do_read(18'h00010, 16'hBEEF, "t2_r0", waited);
    do_read(18'h00011, 16'hCAFE, "t2_r1", waited);

    seen_full = 1'b0;
    base_wr   = m_wr_cnt;
    for (int i = 0; i < 8; i++) begin
      n = 0;
      wr_valid = 1'b1; wr_addr = 18'h40 + 18'(i); wr_data = 16'h5A00 + 16'(i);
      while (!wr_ready && n < 20) begin
        check("t3_ready_full", wr_ready, 32'(m_cnt < 4));
        seen_full = 1'b1;
        @(negedge clk);
        n++;
      end
      check("t3_ready", wr_ready, 32'(m_cnt < 4));
      @(negedge clk);
    end
    wr_valid = 1'b0;
    check("t3_seen_full", seen_full, 1);
    repeat (16) @(negedge clk);
    check("t3_write_count", m_wr_cnt - base_wr, 8);
    for (int i = 0; i < 8; i++) begin
      check("t3_mem", mem[8'(8'h40 + i)], 16'h5A00 + 16'(i));
    end

    push(18'h00020, 16'hAAAA, "t4_pre");
    repeat (8) @(negedge clk);
    n = 0;
    while (m_slot != 1'b0 && n < 4) begin @(negedge clk); n++; end
    wr_valid = 1'b1; wr_addr = 18'h00020; wr_data = 16'h1234;
    @(negedge clk);
    wr_valid = 1'b0;
`ifdef SRAM_SEQ_RAW_STALL_EN
    exp_raw = 16'h1234;
    do_read(18'h00020, exp_raw, "t4_raw", waited);
    check("t4_stalled", 32'(waited > 0), 1);
`else
    exp_raw = 16'hAAAA;
    do_read(18'h00020, exp_raw, "t4_raw", waited);
    check("t4_no_stall", waited, 0);
`endif
    repeat (6) @(negedge clk);
    do_read(18'h00020, 16'h1234, "t4_after", waited);

    base = resp_cnt;
    rd_valid = 1'b1; rd_addr = 18'h00011;
    for (int i = 0; i < 20; i++) begin
      check("t5_rdy_slot", rd_ready, m_slot);
      @(negedge clk);
    end
    rd_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("t5_resp_count", resp_cnt - base, 10);
    check("t5_resp_data", rd_resp_data, 16'hCAFE);

    n = 0;
    while (m_slot != 1'b1 && n < 4) begin @(negedge clk); n++; end
    rd_valid = 1'b1; rd_addr = 18'h00010;
    for (int i = 0; i < 7; i++) begin
      wr_valid = (i < 6);
      wr_addr  = 18'h60 + 18'(i);
      wr_data  = 16'h7700 + 16'(i);
      @(negedge clk);
    end
    check("t6_queued", m_cnt, 3);
    rst_n = 1'b0; wr_valid = 1'b0; rd_valid = 1'b0;
    base    = resp_cnt;
    base_wr = m_wr_cnt;
    @(negedge clk);
    check("t6_rst_w_addr", w_addr, 18'h3FFFF);
    check("t6_rst_wr_ready", wr_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    saw_write = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (w_addr != 18'h3FFFF) saw_write = 1'b1;
    end
    check("t6_no_queued_write", saw_write, 0);
    check("t6_no_resp", resp_cnt - base, 0);
    check("t6_sram_untouched", m_wr_cnt - base_wr, 0);
    check("t6_w_addr", w_addr, 18'h3FFFF);
    check("t6_wr_ready", wr_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
